// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and decode handshake bundle for the fetch stage
interface fetch_unit_if #(parameter int CNT_W = 32);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      npc;
  logic             flush;
  logic [31:0]      flush_pc;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, misalign, fetch_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc, flush, flush_pc
  );
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, misalign, fetch_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc, flush, flush_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and single-outstanding instruction fetch stage
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;
  state_t state, nstate;
  logic [31:0] pc, src;
  logic consume, take, load;
  // next state and load qualifiers; flush overrides any consume or data capture
  always_comb begin
    consume = state == HOLD && bus.inst_ready && !bus.flush;
    take = state == WAIT && bus.imem_rvalid && !bus.flush;
    load = bus.flush || consume;
    src = bus.flush ? bus.flush_pc : bus.npc;
    nstate = state;
    case (state)
      FETCH:   nstate = bus.imem_gnt ? (bus.flush ? DISCARD : WAIT) : FETCH;
      WAIT:    nstate = bus.imem_rvalid ? (bus.flush ? FETCH : HOLD) : (bus.flush ? DISCARD : WAIT);
      HOLD:    nstate = (bus.flush || bus.inst_ready) ? FETCH : HOLD;
      DISCARD: nstate = bus.imem_rvalid ? FETCH : DISCARD;
      default: nstate = FETCH;
    endcase
  end
  assign bus.imem_req = state == FETCH && !rst;
  assign bus.imem_addr = {pc[31:2], 2'b00};
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else state <= nstate;
  end
  // PC, captured instruction, misalign pulse and consume counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      bus.inst <= '0;
      bus.inst_pc <= '0;
      bus.inst_valid <= 1'b0;
      bus.misalign <= 1'b0;
      bus.fetch_cnt <= '0;
    end else begin
      bus.misalign <= load && src[1:0] != 2'b00;
      if (load) pc <= {src[31:2], 2'b00};
      if (take) begin
        bus.inst <= bus.imem_rdata;
        bus.inst_pc <= pc;
      end
      bus.inst_valid <= take ? 1'b1 : (load ? 1'b0 : bus.inst_valid);
      if (consume) bus.fetch_cnt <= bus.fetch_cnt + 1'b1;
    end
  end
endmodule
